// File: rtl/fma_pkg.sv
// fma_pkg: op encodings and default widths shared by the fixed-point FMA pipeline.
package fma_pkg;
    localparam int W_DEF  = 16;
    localparam int MW_DEF = 32;
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;
endpackage

// File: rtl/fma_sat_round.sv
// fma_sat_round: narrows the exact MW+1-bit sum to MW bits with overflow detect.
// Wraps by default; clamps to the signed MW range when FMA_SAT_EN is defined.
module fma_sat_round #(
    parameter int MW = 32
) (
    input  logic [MW:0]   i_sum,
    output logic [MW-1:0] o_res,
    output logic          o_ovf
);
    assign o_ovf = i_sum[MW] ^ i_sum[MW-1];
`ifdef FMA_SAT_EN
    assign o_res = o_ovf ? (i_sum[MW] ? {1'b1, {(MW-1){1'b0}}} : {1'b0, {(MW-1){1'b1}}})
                         : i_sum[MW-1:0];
`else
    assign o_res = i_sum[MW-1:0];
`endif
endmodule

// File: rtl/fixed_fma_pipe.sv
// fixed_fma_pipe: 3-stage signed multiply-add/accumulate pipeline with backpressure.
// Overflowed results wrap unless FMA_SAT_EN is defined (then they clamp).
module fixed_fma_pipe
    import fma_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int MW = MW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  A_input,
    input  logic [W-1:0]  B_input,
    input  logic [MW-1:0] M_input,
    input  logic [1:0]    op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out,
    output logic          ovf,
    output logic          ovf_sticky,
    input  logic          ovf_clr
);
    logic                  w_stall;
    logic                  r_s1_v;
    logic signed [W-1:0]   r_a;
    logic signed [W-1:0]   r_b;
    logic [MW-1:0]         r_s1_m;
    logic [1:0]            r_s1_op;
    logic                  r_s2_v;
    logic signed [2*W-1:0] r_prod;
    logic [MW-1:0]         r_s2_m;
    logic [1:0]            r_s2_op;
    logic [MW-1:0]         r_acc;
    logic [MW:0]           w_p;
    logic [MW:0]           w_m;
    logic [MW:0]           w_acc;
    logic [MW:0]           w_sum;
    logic [MW-1:0]         w_res;
    logic                  w_ovf;

    // One global stall: every stage freezes while the output is blocked.
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s1_m  <= '0;
            r_s1_op <= '0;
        end else if (!w_stall) begin
            r_s1_v  <= in_valid;
            r_a     <= $signed(A_input);
            r_b     <= $signed(B_input);
            r_s1_m  <= M_input;
            r_s1_op <= op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v  <= 1'b0;
            r_prod  <= '0;
            r_s2_m  <= '0;
            r_s2_op <= '0;
        end else if (!w_stall) begin
            r_s2_v  <= r_s1_v;
            r_prod  <= (2*W)'(r_a) * (2*W)'(r_b);
            r_s2_m  <= r_s1_m;
            r_s2_op <= r_s1_op;
        end
    end

    assign w_p   = {{(MW+1-2*W){r_prod[2*W-1]}}, r_prod};
    assign w_m   = {r_s2_m[MW-1], r_s2_m};
    assign w_acc = {r_acc[MW-1], r_acc};
    // acc is written in the same edge the previous result enters S3, so no bypass is needed.
    assign w_sum = (r_s2_op == OP_SUB)  ? w_p - w_m :
                   (r_s2_op == OP_ACC)  ? w_p + w_acc :
                   (r_s2_op == OP_LOAD) ? w_p : w_p + w_m;

    fma_sat_round #(.MW(MW)) u_sat (
        .i_sum(w_sum),
        .o_res(w_res),
        .o_ovf(w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out        <= '0;
            ovf        <= 1'b0;
            r_acc      <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (!w_stall) begin
                out_valid <= r_s2_v;
                if (r_s2_v) begin
                    out <= w_res;
                    ovf <= w_ovf;
                    if (r_s2_op == OP_ACC || r_s2_op == OP_LOAD)
                        r_acc <= w_res;
                end
            end
            ovf_sticky <= (out_valid && out_ready && ovf) || (ovf_sticky && !ovf_clr);
        end
    end
endmodule
